// File: rtl/ahb_lite_addr_decoder_mux_pkg.sv
// Shared AHB-Lite definitions for the address decoder / response mux slice.
// Contents: bus width, HTRANS and HRESP encodings, default-slave state type,
// and a helper that classifies a transfer as active (NONSEQ or SEQ).
package ahb_lite_addr_decoder_mux_pkg;

  localparam int unsigned BUS_WIDTH = 32;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    DEF_IDLE = 2'd0,
    DEF_ERR1 = 2'd1,
    DEF_ERR2 = 2'd2
  } def_state_t;

  // NONSEQ and SEQ both have HTRANS[1] set; IDLE and BUSY never need a response.
  function automatic logic is_active(input logic [1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/ahb_lite_addr_decoder_mux_default_slave.sv
// Default slave for unmapped addresses: answers active transfers with the
// two-cycle AHB ERROR response and counts them with a saturating counter.
// Ports:
//   HCLK, HRESETn    clock, asynchronous active-low reset
//   HREADY           bus HREADY (address phase is accepted when high)
//   active_unmapped  current address phase is unmapped and NONSEQ/SEQ
//   def_hreadyout    HREADYOUT of the default slave
//   def_hresp        HRESP of the default slave
//   ERR_CNT          number of ERROR responses started, saturating
module ahb_lite_default_slave
  import ahb_lite_addr_decoder_mux_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  input  logic             HREADY,
  input  logic             active_unmapped,
  output logic             def_hreadyout,
  output logic             def_hresp,
  output logic [CNT_W-1:0] ERR_CNT
);

  def_state_t state;
  def_state_t next_state;
  logic       err_start;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state <= DEF_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    unique case (state)
      DEF_IDLE: next_state = (HREADY && active_unmapped) ? DEF_ERR1 : DEF_IDLE;
      DEF_ERR1: next_state = DEF_ERR2;
      DEF_ERR2: next_state = (HREADY && active_unmapped) ? DEF_ERR1 : DEF_IDLE;
      default:  next_state = DEF_IDLE;
    endcase
  end

  always_comb begin
    def_hreadyout = 1'b1;
    def_hresp     = HRESP_OKAY;
    unique case (state)
      DEF_IDLE: begin
        def_hreadyout = 1'b1;
        def_hresp     = HRESP_OKAY;
      end
      DEF_ERR1: begin
        def_hreadyout = 1'b0;
        def_hresp     = HRESP_ERROR;
      end
      DEF_ERR2: begin
        def_hreadyout = 1'b1;
        def_hresp     = HRESP_ERROR;
      end
      default: begin
        def_hreadyout = 1'b1;
        def_hresp     = HRESP_OKAY;
      end
    endcase
  end

  // ERR1 is only ever entered from IDLE or ERR2, so every ERR1 entry is a new error.
  assign err_start = (next_state == DEF_ERR1);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      ERR_CNT <= '0;
    end else if (err_start && (ERR_CNT != '1)) begin
      ERR_CNT <= ERR_CNT + 1'b1;
    end
  end

endmodule

// File: rtl/ahb_lite_addr_decoder_mux.sv
// AHB-Lite interconnect front end for a single master and NUM_SLAVES slaves.
// Decodes the top SEL_BITS of HADDR into a one-hot HSEL, registers the
// data-phase owner and muxes that owner's response back to the master.
// Unmapped addresses are served by an embedded default slave.
// Ports:
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   HADDR, HTRANS  master address phase
//   HSEL           one-hot slave select (combinational from HADDR)
//   HRDATA_S, HREADYOUT_S, HRESP_S  packed per-slave responses
//   HRDATA, HREADY, HRESP           response to master (HREADY also to slaves)
//   ERR_CNT        saturating count of unmapped ERROR responses
module ahb_lite_addr_decoder_mux
  import ahb_lite_addr_decoder_mux_pkg::*;
#(
  parameter int unsigned NUM_SLAVES = 4,
  parameter int unsigned ADDR_W     = BUS_WIDTH,
  parameter int unsigned DATA_W     = BUS_WIDTH,
  parameter int unsigned SEL_BITS   = 4,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                         HCLK,
  input  logic                         HRESETn,
  input  logic [ADDR_W-1:0]            HADDR,
  input  logic [1:0]                   HTRANS,
  output logic [NUM_SLAVES-1:0]        HSEL,
  input  logic [NUM_SLAVES*DATA_W-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]        HRESP_S,
  output logic [DATA_W-1:0]            HRDATA,
  output logic                         HREADY,
  output logic                         HRESP,
  output logic [CNT_W-1:0]             ERR_CNT
);

  localparam int unsigned DSEL_W = $clog2(NUM_SLAVES + 1);
  localparam logic [DSEL_W-1:0] DSEL_DEF = DSEL_W'(NUM_SLAVES);

  logic [SEL_BITS-1:0] slot;
  logic [DSEL_W-1:0]   dec_idx;
  logic [DSEL_W-1:0]   dsel;
  logic                mapped;
  logic                active_unmapped;
  logic                def_hreadyout;
  logic                def_hresp;
  logic                unused_addr_bits;

  assign slot = HADDR[ADDR_W-1 -: SEL_BITS];

  // Only the decoded slot bits and HTRANS[1] carry meaning here.
  assign unused_addr_bits = &{1'b0, HADDR[ADDR_W-SEL_BITS-1:0], HTRANS[0]};

  always_comb begin
    HSEL    = '0;
    dec_idx = DSEL_DEF;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (slot == SEL_BITS'(i)) begin
        HSEL[i] = 1'b1;
        dec_idx = DSEL_W'(i);
      end
    end
  end

  assign mapped          = |HSEL;
  assign active_unmapped = !mapped && is_active(HTRANS);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dsel <= DSEL_DEF;
    end else if (HREADY) begin
      dsel <= dec_idx;
    end
  end

  ahb_lite_default_slave #(
    .CNT_W (CNT_W)
  ) u_default_slave (
    .HCLK            (HCLK),
    .HRESETn         (HRESETn),
    .HREADY          (HREADY),
    .active_unmapped (active_unmapped),
    .def_hreadyout   (def_hreadyout),
    .def_hresp       (def_hresp),
    .ERR_CNT         (ERR_CNT)
  );

  // HREADY depends only on registered dsel and slave outputs, so feeding it
  // back into the dsel register and default slave forms no combinational loop.
  always_comb begin
    HRDATA = '0;
    HREADY = def_hreadyout;
    HRESP  = def_hresp;
    for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
      if (dsel == DSEL_W'(i)) begin
        HRDATA = HRDATA_S[i*DATA_W +: DATA_W];
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_addr_decoder_mux.sv
module tb_ahb_lite_addr_decoder_mux;
  import ahb_lite_addr_decoder_mux_pkg::*;

  localparam int NS = 4;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SB = 4;
  localparam int CW = 2;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [AW-1:0]     HADDR;
  logic [1:0]        HTRANS;
  logic [NS-1:0]     HSEL;
  logic [NS*DW-1:0]  HRDATA_S;
  logic [NS-1:0]     HREADYOUT_S;
  logic [NS-1:0]     HRESP_S;
  logic [DW-1:0]     HRDATA;
  logic              HREADY;
  logic              HRESP;
  logic [CW-1:0]     ERR_CNT;

  always #5 HCLK = ~HCLK;

  ahb_lite_addr_decoder_mux #(
    .NUM_SLAVES (NS),
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .SEL_BITS   (SB),
    .CNT_W      (CW)
  ) dut (
    .HCLK        (HCLK),
    .HRESETn     (HRESETn),
    .HADDR       (HADDR),
    .HTRANS      (HTRANS),
    .HSEL        (HSEL),
    .HRDATA_S    (HRDATA_S),
    .HREADYOUT_S (HREADYOUT_S),
    .HRESP_S     (HRESP_S),
    .HRDATA      (HRDATA),
    .HREADY      (HREADY),
    .HRESP       (HRESP),
    .ERR_CNT     (ERR_CNT)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Simple slave models: fixed data, configurable wait states, optional ERROR.
  logic [31:0] cfg_data  [NS];
  int          cfg_waits [NS];
  logic        cfg_err   [NS];
  logic        s_active  [NS];
  int          s_wcnt    [NS];

  always @(posedge HCLK or negedge HRESETn) begin
    for (int i = 0; i < NS; i++) begin
      if (!HRESETn) begin
        s_active[i] <= 1'b0;
        s_wcnt[i]   <= 0;
      end else if (HREADY) begin
        s_active[i] <= HSEL[i] && HTRANS[1];
        s_wcnt[i]   <= cfg_waits[i];
      end else if (s_wcnt[i] > 0) begin
        s_wcnt[i] <= s_wcnt[i] - 1;
      end
    end
  end

  always_comb begin
    HREADYOUT_S = '0;
    HRESP_S     = '0;
    HRDATA_S    = '0;
    for (int i = 0; i < NS; i++) begin
      HREADYOUT_S[i]         = !(s_active[i] && (s_wcnt[i] != 0));
      HRESP_S[i]             = s_active[i] && cfg_err[i];
      HRDATA_S[i*DW +: DW]   = cfg_data[i];
    end
  end

  // Scoreboard
  typedef struct {
    logic [31:0]   rdata;
    logic          resp;
    int            waits;
    logic          wait_resp;
    logic [CW-1:0] cnt;
    string         name;
  } exp_t;

  exp_t q[$];
  logic tracked = 1'b0;
  logic in_dphase = 1'b0;
  int   mwaits = 0;

  always @(negedge HCLK) begin
    exp_t e;
    if (!HRESETn) begin
      in_dphase <= 1'b0;
    end else begin
      if (in_dphase) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL scoreboard_empty: got data phase, expected none");
          in_dphase <= 1'b0;
        end else if (!HREADY) begin
          check({q[0].name, "_wait_resp"}, HRESP, q[0].wait_resp);
          mwaits <= mwaits + 1;
        end else begin
          e = q.pop_front();
          check({e.name, "_rdata"}, HRDATA, e.rdata);
          check({e.name, "_resp"},  HRESP,  e.resp);
          check({e.name, "_waits"}, mwaits, e.waits);
          check({e.name, "_cnt"},   ERR_CNT, e.cnt);
          in_dphase <= 1'b0;
        end
      end
      if (HREADY && tracked) begin
        in_dphase <= 1'b1;
        mwaits    <= 0;
      end
    end
  end

  task automatic xfer(input logic [31:0] a, input logic [1:0] t, input logic trk,
                      input logic [31:0] rd, input logic rs, input int w,
                      input logic wr, input logic [CW-1:0] c, input string nm);
    bit ok;
    HADDR   = a;
    HTRANS  = t;
    tracked = trk;
    if (trk) q.push_back('{rd, rs, w, wr, c, nm});
    ok = 1'b0;
    for (int n = 0; n < 20; n++) begin
      @(negedge HCLK);
      if (HREADY) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL %s_accept: got HREADY=0 for 20 cycles, expected acceptance", nm);
    end
    @(posedge HCLK);
    #1;
  endtask

  task automatic go_idle(input int cycles);
    HTRANS  = HTRANS_IDLE;
    HADDR   = 32'h0000_0000;
    tracked = 1'b0;
    repeat (cycles) @(posedge HCLK);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    fails++;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1);
  end

  initial begin
    cfg_data[0] = 32'hA0A0_A0A0; cfg_waits[0] = 0; cfg_err[0] = 1'b0;
    cfg_data[1] = 32'h1111_1111; cfg_waits[1] = 0; cfg_err[1] = 1'b0;
    cfg_data[2] = 32'hCAFE_F00D; cfg_waits[2] = 1; cfg_err[2] = 1'b0;
    cfg_data[3] = 32'hD3D3_D3D3; cfg_waits[3] = 1; cfg_err[3] = 1'b1;
    HRESETn = 1'b0;
    HADDR   = 32'h0000_0000;
    HTRANS  = HTRANS_IDLE;

    #12;
    check("rst_hready", HREADY, 1'b1);
    check("rst_hresp",  HRESP,  1'b0);
    check("rst_hrdata", HRDATA, 32'h0);
    check("rst_errcnt", ERR_CNT, 2'd0);

    // Decode sweep (HSEL is combinational even under reset)
    HADDR = 32'h0000_0000; #1 check("hsel_s0",  HSEL, 4'b0001);
    HADDR = 32'h1000_0000; #1 check("hsel_s1",  HSEL, 4'b0010);
    HADDR = 32'h2000_0000; #1 check("hsel_s2",  HSEL, 4'b0100);
    HADDR = 32'h3FFF_FFFC; #1 check("hsel_s3",  HSEL, 4'b1000);
    HADDR = 32'h4000_0000; #1 check("hsel_unm", HSEL, 4'b0000);
    HADDR = 32'hF000_0000; #1 check("hsel_top", HSEL, 4'b0000);

    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;

    // Reset in the middle of an ERROR response
    xfer(32'h8000_0000, HTRANS_NONSEQ, 1'b0, 32'h0, 1'b0, 0, 1'b0, 2'd0, "pre_rst");
    check("err1_hready", HREADY, 1'b0);
    check("err1_errcnt", ERR_CNT, 2'd1);
    HTRANS = HTRANS_IDLE;
    #2 HRESETn = 1'b0;
    #1;
    check("midrst_hready", HREADY, 1'b1);
    check("midrst_hresp",  HRESP,  1'b0);
    check("midrst_hrdata", HRDATA, 32'h0);
    check("midrst_errcnt", ERR_CNT, 2'd0);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    check("postrst_hready", HREADY, 1'b1);
    check("postrst_hresp",  HRESP,  1'b0);
    check("postrst_hrdata", HRDATA, 32'h0);

    // Scoreboarded transfers
    xfer(32'h2000_0010, HTRANS_NONSEQ, 1'b1, 32'hCAFE_F00D, 1'b0, 1, 1'b0, 2'd0, "rd_s2");
    xfer(32'h8000_0000, HTRANS_NONSEQ, 1'b1, 32'h0,         1'b1, 1, 1'b1, 2'd1, "unm_nonseq");
    xfer(32'h9000_0004, HTRANS_SEQ,    1'b1, 32'h0,         1'b1, 1, 1'b1, 2'd2, "unm_seq");
    xfer(32'h1000_0000, HTRANS_NONSEQ, 1'b1, 32'h1111_1111, 1'b0, 0, 1'b0, 2'd2, "b2b_s1");
    xfer(32'hF000_0000, HTRANS_IDLE,   1'b1, 32'h0,         1'b0, 0, 1'b0, 2'd2, "unm_idle");
    xfer(32'hC000_0000, HTRANS_BUSY,   1'b1, 32'h0,         1'b0, 0, 1'b0, 2'd2, "unm_busy");
    xfer(32'h3000_0000, HTRANS_NONSEQ, 1'b1, 32'hD3D3_D3D3, 1'b1, 1, 1'b1, 2'd2, "s3_error");
    xfer(32'h0000_0100, HTRANS_NONSEQ, 1'b1, 32'hA0A0_A0A0, 1'b0, 0, 1'b0, 2'd2, "rd_s0");
    go_idle(4);
    check("drain1", q.size(), 0);

    // Saturation from a fresh reset
    HRESETn = 1'b0;
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    xfer(32'hA000_0000, HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1, 1, 1'b1, 2'd1, "sat1");
    xfer(32'hB000_0000, HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1, 1, 1'b1, 2'd2, "sat2");
    xfer(32'hC000_0000, HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1, 1, 1'b1, 2'd3, "sat3");
    xfer(32'hD000_0000, HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1, 1, 1'b1, 2'd3, "sat4");
    xfer(32'hE000_0000, HTRANS_NONSEQ, 1'b1, 32'h0, 1'b1, 1, 1'b1, 2'd3, "sat5");
    go_idle(4);
    check("drain2", q.size(), 0);
    check("sat_final", ERR_CNT, 2'd3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
